// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
// Tag id is sized for the largest supported requester count.
package divider_arbiter_pkg;

    localparam int DIV_WIDTH   = 9;
    localparam int DIV_LATENCY = 4;
    localparam int MAX_REQ     = 8;
    localparam int ID_W        = $clog2(MAX_REQ);

    typedef struct packed {
        logic                 valid;
        logic [ID_W-1:0]      id;
        logic                 dz;
        logic [DIV_WIDTH-1:0] a;
    } div_tag_t;

endpackage

// File: rtl/divider_arbiter_div.sv
// Pipelined unsigned restoring divider, LAT register stages.
// Data registers carry no reset; validity is tracked by the caller.
module divider_arbiter_div #(
    parameter int W   = 9,
    parameter int LAT = 4
) (
    input  logic         clk_in,
    input  logic [W-1:0] dividend_in,
    input  logic [W-1:0] divisor_in,
    output logic [W-1:0] quotient_out,
    output logic [W-1:0] remainder_out
);

    localparam int STEPS = (W + LAT - 1) / LAT;

    logic [W-1:0] rem_q [1:LAT];
    logic [W-1:0] quo_q [1:LAT];
    logic [W-1:0] dvs_q [1:LAT];

    logic [W-1:0] in_r [0:LAT-1];
    logic [W-1:0] in_q [0:LAT-1];
    logic [W-1:0] in_b [0:LAT-1];
    logic [W-1:0] nx_r [0:LAT-1];
    logic [W-1:0] nx_q [0:LAT-1];

    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W:0]   t;

    // Each stage retires STEPS quotient bits, MSB first.
    always_comb begin
        r = '0;
        q = '0;
        t = '0;
        in_r[0] = '0;
        in_q[0] = dividend_in;
        in_b[0] = divisor_in;
        for (int s = 1; s < LAT; s++) begin
            in_r[s] = rem_q[s];
            in_q[s] = quo_q[s];
            in_b[s] = dvs_q[s];
        end
        for (int s = 0; s < LAT; s++) begin
            r = in_r[s];
            q = in_q[s];
            for (int k = 0; k < STEPS; k++) begin
                if (s * STEPS + k < W) begin
                    t = {r, q[W-1]};
                    q = {q[W-2:0], 1'b0};
                    if (t >= {1'b0, in_b[s]}) begin
                        t    = t - {1'b0, in_b[s]};
                        q[0] = 1'b1;
                    end
                    r = t[W-1:0];
                end
            end
            nx_r[s] = r;
            nx_q[s] = q;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < LAT; s++) begin
            rem_q[s+1] <= nx_r[s];
            quo_q[s+1] <= nx_q[s];
            dvs_q[s+1] <= in_b[s];
        end
    end

    assign quotient_out  = quo_q[LAT];
    assign remainder_out = rem_q[LAT];

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one pipelined divider among NUM_REQ requesters.
// Results return tagged by requester on a one-hot strobe bus.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 9,
    parameter int DIV_LATENCY = 4,
    localparam int PTR_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       res_valid_out,
    output logic [PTR_W-1:0]         res_id_out,
    output logic [WIDTH-1:0]         res_quotient_out,
    output logic [WIDTH-1:0]         res_remainder_out,
    output logic                     res_div_zero_out,
    output logic                     busy_out
);

    if (WIDTH != DIV_WIDTH) begin : g_bad_width
        $error("divider_arbiter: WIDTH must equal DIV_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("divider_arbiter: NUM_REQ out of range");
    end

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] grant;
    logic [PTR_W:0]   scan;
    logic             found;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    div_tag_t         tag_d;
    div_tag_t         tag_q [0:DIV_LATENCY];
    div_tag_t         tail;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_in[scan[PTR_W-1:0]]) begin
                found = 1'b1;
                grant = scan[PTR_W-1:0];
            end
        end
    end

    assign accept        = found && !flush_in;
    assign req_ready_out = accept ? (NUM_REQ'(1) << grant) : '0;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == PTR_W'(i)) begin
                sel_a = req_dividend_in[i*WIDTH +: WIDTH];
                sel_b = req_divisor_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = accept;
        tag_d.id    = ID_W'(grant);
        tag_d.dz    = (sel_b == '0);
        tag_d.a     = sel_a;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr_q <= '0;
        end else if (accept) begin
            if (grant == PTR_W'(NUM_REQ - 1)) ptr_q <= '0;
            else                              ptr_q <= grant + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            opa_q <= sel_a;
            opb_q <= sel_b;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i <= DIV_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= DIV_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            if (flush_in) begin
                for (int i = 0; i <= DIV_LATENCY; i++) tag_q[i].valid <= 1'b0;
            end
        end
    end

    divider_arbiter_div #(
        .W   (WIDTH),
        .LAT (DIV_LATENCY)
    ) u_div (
        .clk_in        (clk_in),
        .dividend_in   (opa_q),
        .divisor_in    (opb_q),
        .quotient_out  (div_q),
        .remainder_out (div_r)
    );

    assign tail = tag_q[DIV_LATENCY];

    // Result fields hold their last value between strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            res_valid_out     <= '0;
            res_id_out        <= '0;
            res_quotient_out  <= '0;
            res_remainder_out <= '0;
            res_div_zero_out  <= 1'b0;
        end else begin
            res_valid_out <= '0;
            if (tail.valid && !flush_in) begin
                res_valid_out     <= NUM_REQ'(1) << tail.id;
                res_id_out        <= PTR_W'(tail.id);
                res_quotient_out  <= tail.dz ? '1 : div_q;
                res_remainder_out <= tail.dz ? tail.a : div_r;
                res_div_zero_out  <= tail.dz;
            end
        end
    end

    always_comb begin
        busy_out = |res_valid_out;
        for (int i = 0; i <= DIV_LATENCY; i++) begin
            busy_out = busy_out | tag_q[i].valid;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter against a queue-based reference.
// Expected results come from plain integer division of accepted ops.
module tb_divider_arbiter;

    localparam int N   = 4;
    localparam int W   = 9;
    localparam int LAT = 4;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic           flush_in = 1'b0;
    logic [N-1:0]   req_valid_in = '0;
    logic [N*W-1:0] req_dividend_in = '0;
    logic [N*W-1:0] req_divisor_in = '0;
    logic [N-1:0]   req_ready_out;
    logic [N-1:0]   res_valid_out;
    logic [1:0]     res_id_out;
    logic [W-1:0]   res_quotient_out;
    logic [W-1:0]   res_remainder_out;
    logic           res_div_zero_out;
    logic           busy_out;

    divider_arbiter #(
        .NUM_REQ     (N),
        .WIDTH       (W),
        .DIV_LATENCY (LAT)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .flush_in          (flush_in),
        .req_valid_in      (req_valid_in),
        .req_dividend_in   (req_dividend_in),
        .req_divisor_in    (req_divisor_in),
        .req_ready_out     (req_ready_out),
        .res_valid_out     (res_valid_out),
        .res_id_out        (res_id_out),
        .res_quotient_out  (res_quotient_out),
        .res_remainder_out (res_remainder_out),
        .res_div_zero_out  (res_div_zero_out),
        .busy_out          (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int due;
        int id;
        int a;
        int b;
    } op_t;

    op_t pend[$];
    int  ptr;
    int  cyc;
    int  n_tests;
    int  n_fail;
    int  last_q;
    int  last_r;
    int  last_id;
    int  last_dz;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(int i, int a, int b);
        req_dividend_in[i*W +: W] = W'(a);
        req_divisor_in[i*W +: W]  = W'(b);
    endtask

    // One clock: check grant, apply the edge to the model, check results.
    task automatic tick();
        logic         fnd;
        int           g;
        logic [N-1:0] er;
        logic         vnow;
        #1;
        fnd = 1'b0;
        g   = 0;
        if (!flush_in) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (ptr + i) % N;
                if (!fnd && req_valid_in[j]) begin
                    fnd = 1'b1;
                    g   = j;
                end
            end
        end
        er = fnd ? N'(1 << g) : '0;
        check("ready", req_ready_out, er);
        @(posedge clk_in);
        cyc++;
        if (flush_in) pend.delete();
        if (fnd) begin
            op_t o;
            o.due = cyc + LAT + 1;
            o.id  = g;
            o.a   = int'(req_dividend_in[g*W +: W]);
            o.b   = int'(req_divisor_in[g*W +: W]);
            pend.push_back(o);
            ptr = (g + 1) % N;
        end
        @(negedge clk_in);
        vnow = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            op_t o;
            o = pend.pop_front();
            vnow = 1'b1;
            if (o.b == 0) begin
                last_q  = 511;
                last_r  = o.a;
                last_dz = 1;
            end else begin
                last_q  = o.a / o.b;
                last_r  = o.a % o.b;
                last_dz = 0;
            end
            last_id = o.id;
            check("res_valid", res_valid_out, 1 << o.id);
            check("res_id", res_id_out, last_id);
            check("quotient", res_quotient_out, last_q);
            check("remainder", res_remainder_out, last_r);
            check("div_zero", res_div_zero_out, last_dz);
        end else begin
            check("res_idle", res_valid_out, 0);
            check("hold_q", res_quotient_out, last_q);
            check("hold_id", res_id_out, last_id);
        end
        check("busy", busy_out, (pend.size() > 0 || vnow) ? 1 : 0);
    endtask

    task automatic do_reset();
        req_valid_in = '0;
        flush_in     = 1'b0;
        rst_in       = 1'b0;
        #1;
        check("rst_valid", res_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_q", res_quotient_out, 0);
        check("rst_r", res_remainder_out, 0);
        check("rst_id", res_id_out, 0);
        check("rst_dz", res_div_zero_out, 0);
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        pend.delete();
        ptr     = 0;
        last_q  = 0;
        last_r  = 0;
        last_id = 0;
        last_dz = 0;
        rst_in  = 1'b1;
    endtask

    task automatic idle(int n);
        req_valid_in = '0;
        repeat (n) tick();
    endtask

    int bnd_a [4] = '{511, 5, 511, 0};
    int bnd_b [4] = '{1, 9, 511, 3};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        ptr     = 0;
        @(negedge clk_in);
        do_reset();

        // single op
        set_op(0, 200, 7);
        req_valid_in = 4'b0001;
        tick();
        idle(7);

        // full contention
        for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 511), $urandom_range(1, 511));
        req_valid_in = 4'b1111;
        repeat (8) tick();
        idle(7);

        // divide by zero next to a normal op
        set_op(1, 100, 10);
        set_op(2, 311, 0);
        req_valid_in = 4'b0110;
        tick();
        req_valid_in = 4'b0100;
        tick();
        idle(7);

        // boundaries, back-to-back from a sole requester
        for (int i = 0; i < 4; i++) begin
            set_op(0, bnd_a[i], bnd_b[i]);
            req_valid_in = 4'b0001;
            tick();
        end
        idle(7);

        // reset with ops in flight
        for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 511), $urandom_range(1, 511));
        req_valid_in = 4'b0111;
        repeat (3) tick();
        do_reset();
        set_op(1, 450, 13);
        set_op(3, 77, 5);
        req_valid_in = 4'b1010;
        tick();
        idle(8);

        // flush with four in flight
        for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 511), $urandom_range(0, 511));
        req_valid_in = 4'b1111;
        repeat (4) tick();
        req_valid_in = 4'b1000;
        flush_in     = 1'b1;
        tick();
        flush_in = 1'b0;
        tick();
        idle(8);

        // random traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, $urandom_range(0, 511),
                       ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 511));
            end
            req_valid_in = N'($urandom);
            flush_in     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush_in = 1'b0;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
